// File: rtl/cam_capture.sv
// Camera byte capture: sync to VSYNC, gate HREF bytes of enabled frames; 2-cycle pin-to-output latency, no backpressure.
// Define CAM_LINE_CHECK_EN to add line-length/line-count checking reported on frame_err.
module cam_capture #(
   parameter int H_BYTES = 640,
   parameter int V_LINES = 240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       href,
   input  logic [7:0] d,
   input  logic       capture_en,
   output logic [7:0] cam_data,
   output logic       pix_valid,
   output logic       frame_done,
   output logic [7:0] frame_cnt,
   output logic       frame_err,
   output logic [1:0] FSM_state
);

   typedef enum logic [1:0] {SYNC = 2'd0, WAIT = 2'd1, ACTIVE = 2'd2, DONE = 2'd3} state_t;

   state_t     state_q, state_d;
   logic       vs1_q, vs1_d, hr1_q, hr1_d, vs_prev_q, vs_prev_d;
   logic [7:0] d1_q, d1_d;
   logic [7:0] cam_data_q, cam_data_d;
   logic       pix_valid_q, pix_valid_d;
   logic       frame_done_q, frame_done_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       vs_rise, vs_fall;

   assign vs_rise = vs1_q & ~vs_prev_q;
   assign vs_fall = ~vs1_q & vs_prev_q;

   always_comb begin
      vs1_d        = vsync;
      hr1_d        = href;
      d1_d         = d;
      vs_prev_d    = vs1_q;
      state_d      = state_q;
      cam_data_d   = cam_data_q;
      pix_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      case (state_q)
         SYNC:   if (vs1_q) state_d = WAIT;
         WAIT:   if (vs_fall && capture_en) state_d = ACTIVE;
         ACTIVE: begin
            // A byte arriving with the vsync edge is dropped so frame_done never overlaps pix_valid.
            if (vs_rise) begin
               state_d      = DONE;
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 8'd1;
            end else if (hr1_q) begin
               pix_valid_d = 1'b1;
               cam_data_d  = d1_q;
            end
         end
         DONE:    state_d = WAIT;
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= SYNC;
         vs1_q        <= 1'b0;
         hr1_q        <= 1'b0;
         d1_q         <= 8'd0;
         vs_prev_q    <= 1'b0;
         cam_data_q   <= 8'd0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         vs1_q        <= vs1_d;
         hr1_q        <= hr1_d;
         d1_q         <= d1_d;
         vs_prev_q    <= vs_prev_d;
         cam_data_q   <= cam_data_d;
         pix_valid_q  <= pix_valid_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

`ifdef CAM_LINE_CHECK_EN
   localparam logic [10:0] H_CNT = 11'(H_BYTES);
   localparam logic [8:0]  V_CNT = 9'(V_LINES);

   logic        hr_prev_q, hr_prev_d;
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [8:0]  line_cnt_q, line_cnt_d;
   logic        line_bad_q, line_bad_d;
   logic        frame_err_q, frame_err_d;
   logic        line_end, frame_bad;

   always_comb begin
      line_end    = hr_prev_q & ~hr1_q;
      hr_prev_d   = hr1_q;
      byte_cnt_d  = byte_cnt_q;
      line_cnt_d  = line_cnt_q;
      line_bad_d  = line_bad_q;
      frame_err_d = frame_err_q;
      if (state_q == ACTIVE) begin
         if (hr1_q) byte_cnt_d = byte_cnt_q + 11'd1;
         if (line_end) begin
            byte_cnt_d = 11'd0;
            line_cnt_d = line_cnt_q + 9'd1;
            if (byte_cnt_q != H_CNT) line_bad_d = 1'b1;
         end
      end else if (state_q == DONE) begin
         byte_cnt_d = 11'd0;
         line_cnt_d = 9'd0;
         line_bad_d = 1'b0;
      end
      // A nonzero byte count at the vsync edge means the last line was cut short.
      frame_bad = line_bad_d | (byte_cnt_d != 11'd0) | (line_cnt_d != V_CNT);
      if (state_q == ACTIVE && vs_rise) frame_err_d = frame_bad;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hr_prev_q   <= 1'b0;
         byte_cnt_q  <= 11'd0;
         line_cnt_q  <= 9'd0;
         line_bad_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         hr_prev_q   <= hr_prev_d;
         byte_cnt_q  <= byte_cnt_d;
         line_cnt_q  <= line_cnt_d;
         line_bad_q  <= line_bad_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

   assign cam_data   = cam_data_q;
   assign pix_valid  = pix_valid_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign FSM_state  = state_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture using a reduced 8-byte x 4-line frame geometry.
module tb_cam_capture;
   localparam int H = 8;
   localparam int V = 4;
`ifdef CAM_LINE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk, reset, vsync, href, capture_en;
   logic [7:0] d;
   logic [7:0] cam_data, frame_cnt;
   logic       pix_valid, frame_done, frame_err;
   logic [1:0] FSM_state;

   cam_capture #(.H_BYTES(H), .V_LINES(V)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .href(href), .d(d),
      .capture_en(capture_en), .cam_data(cam_data), .pix_valid(pix_valid),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .frame_err(frame_err),
      .FSM_state(FSM_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int seed  = 0;
   bit cap   = 1'b0;
   logic vs_last = 1'b0;
   logic [7:0] exp_cnt = 8'd0;
   logic exp_err = 1'b0;
   // Expected outputs for the previous two driven cycles (h1 is two cycles old).
   logic h0_pv = 1'b0, h1_pv = 1'b0, h0_fd = 1'b0, h1_fd = 1'b0;
   logic [7:0] h0_d = 8'd0, h1_d = 8'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_hist();
      h0_pv = 1'b0; h1_pv = 1'b0; h0_fd = 1'b0; h1_fd = 1'b0;
      h0_d = 8'd0; h1_d = 8'd0;
   endtask

   task automatic step(input logic vs, input logic hr, input logic [7:0] dd);
      @(negedge clk);
      check("pix_valid", {31'd0, pix_valid}, {31'd0, h1_pv});
      check("frame_done", {31'd0, frame_done}, {31'd0, h1_fd});
      if (h1_pv) check("cam_data", {24'd0, cam_data}, {24'd0, h1_d});
      h1_pv = h0_pv; h1_fd = h0_fd; h1_d = h0_d;
      h0_pv = cap && hr && !vs;
      h0_fd = cap && vs && !vs_last;
      h0_d  = dd;
      vsync = vs; href = hr; d = dd; vs_last = vs;
   endtask

   task automatic preamble();
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'hAA);
      step(1'b1, 1'b0, 8'h00);
   endtask

   // Frame: vsync low blanking, lines, then vsync high (whose first cycle is the rising edge).
   task automatic frame(input bit capt, input logic en, input bit flip, input int short_ln,
                        input int nlines, input bit bad);
      capture_en = en;
      cap = capt;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
      for (int l = 0; l < nlines; l++) begin
         for (int b = 0; b < ((l == short_ln) ? H - 1 : H); b++)
            step(1'b0, 1'b1, 8'(l * H + b + seed));
         step(1'b0, 1'b0, 8'h00);
         step(1'b0, 1'b0, 8'h00);
         if (l == 0 && flip) capture_en = ~en;
      end
      check("state_mid", {30'd0, FSM_state}, capt ? 32'd2 : 32'd1);
      preamble();
      cap = 1'b0;
      if (capt) begin
         exp_cnt = exp_cnt + 8'd1;
         exp_err = CHK && bad;
      end
      check("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
      check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
      seed = seed + 37;
   endtask

   initial begin
      reset = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00; capture_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", {30'd0, FSM_state}, 32'd0);
      check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      check("rst_cam_data", {24'd0, cam_data}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      reset = 1'b1;

      // Partial frame after reset must be dropped until vsync is seen.
      for (int i = 0; i < 12; i++) step(1'b0, 1'(i % 3 != 0), 8'(i + 8'h50));
      check("sync_hold", {30'd0, FSM_state}, 32'd0);
      preamble();
      check("wait_state", {30'd0, FSM_state}, 32'd1);

      frame(1'b1, 1'b1, 1'b0, -1, V, 1'b0);   // good frame
      frame(1'b1, 1'b1, 1'b0, 1, V, 1'b1);    // one line of H-1 bytes
      frame(1'b1, 1'b1, 1'b0, -1, V, 1'b0);   // recovery
      frame(1'b0, 1'b0, 1'b1, -1, V, 1'b0);   // skipped, enable raised mid-frame
      frame(1'b1, 1'b1, 1'b1, -1, V, 1'b0);   // enable dropped mid-frame, still captured
      frame(1'b1, 1'b1, 1'b0, -1, 2, 1'b1);   // vsync after too few lines

      // Reset in the middle of a captured line.
      capture_en = 1'b1;
      cap = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(i + 8'h10));
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_state", {30'd0, FSM_state}, 32'd0);
      check("mid_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      check("mid_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
      cap = 1'b0;
      clear_hist();
      exp_cnt = 8'd0;
      exp_err = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 1'(i % 2), 8'(i));
      reset = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 4 != 3), 8'(i + 8'h30));
      check("post_rst_sync", {30'd0, FSM_state}, 32'd0);
      preamble();

      // 256 good frames after reset bring frame_cnt back to 0.
      for (int f = 0; f < 256; f++) frame(1'b1, 1'b1, 1'b0, -1, V, 1'b0);
      check("cnt_wrap", {24'd0, frame_cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
